// File: rtl/divisor_sequencial_pkg.sv
// Shared constants and FSM encoding for the sequential restoring divider.
// The remainder output is built only when DIV_RESTO_EN is defined.
package divisor_sequencial_pkg;

  localparam int LARGURA_PADRAO = 8;
  localparam int ITERACOES = 8;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  localparam logic [LARGURA_PADRAO-1:0] QUOC_DIV0 = 8'hFF;

endpackage

// File: rtl/divisor_sequencial_if.sv
// Operand/result bundle of the sequential divider; resto exists only with DIV_RESTO_EN.
interface divisor_sequencial_if
  import divisor_sequencial_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) ();

  logic               iniciar;
  logic [LARGURA-1:0] A;
  logic [LARGURA-1:0] B;
  logic [LARGURA-1:0] quociente;
`ifdef DIV_RESTO_EN
  logic [LARGURA-1:0] resto;
`endif
  logic               ocupado;
  logic               pronto;
  logic               erro_div0;

  modport master (
    output iniciar, A, B,
    input  quociente, ocupado, pronto, erro_div0
`ifdef DIV_RESTO_EN
    , input resto
`endif
  );

  modport slave (
    input  iniciar, A, B,
    output quociente, ocupado, pronto, erro_div0
`ifdef DIV_RESTO_EN
    , output resto
`endif
  );

endinterface

// File: rtl/divisor_sequencial_subtrator9.sv
// Combinational (LARGURA+1)-bit subtractor with borrow out for one restoring step.
module subtrator9 #(
  parameter int LARGURA = 8
) (
  input  logic [LARGURA:0] minuendo,
  input  logic [LARGURA:0] subtraendo,
  output logic [LARGURA:0] diferenca,
  output logic             emprestimo
);

  assign {emprestimo, diferenca} = {1'b0, minuendo} - {1'b0, subtraendo};

endmodule

// File: rtl/divisor_sequencial.sv
// Sequential restoring divider: OCIOSO -> CALCULA (8 steps + result transfer) -> FIM.
// Optional remainder port guarded by macro DIV_RESTO_EN.
module divisor_sequencial
  import divisor_sequencial_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input logic                 clk,
  input logic                 rst,
  divisor_sequencial_if.slave bus
);

  localparam int CNT_W = $clog2(ITERACOES + 1);

  estado_t            estado, prox_estado;
  logic [LARGURA-1:0] dividendo_sh;
  logic [LARGURA-1:0] divisor_r;
  logic [LARGURA-1:0] resto_parc;
  logic [LARGURA-1:0] quoc_r;
`ifdef DIV_RESTO_EN
  logic [LARGURA-1:0] resto_r;
`endif
  logic [CNT_W-1:0]   cnt;
  logic               ocupado_r, pronto_r, erro_r;
  logic               aceitar, passo, concluir, div0;

  logic [LARGURA:0]   parcial;
  logic [LARGURA:0]   diferenca;
  logic               emprestimo;
  logic               unused_bits;

  assign div0    = (bus.B == '0);
  assign parcial = {resto_parc, dividendo_sh[LARGURA-1]};

  subtrator9 #(.LARGURA(LARGURA)) u_sub (
    .minuendo   (parcial),
    .subtraendo ({1'b0, divisor_r}),
    .diferenca  (diferenca),
    .emprestimo (emprestimo)
  );

  // The partial remainder stays below the divisor, so the top bits never carry information.
  assign unused_bits = ^{diferenca[LARGURA], parcial[LARGURA]};

  always_ff @(posedge clk) begin
    if (rst) estado <= OCIOSO;
    else     estado <= prox_estado;
  end

  always_comb begin
    prox_estado = estado;
    aceitar     = 1'b0;
    passo       = 1'b0;
    concluir    = 1'b0;
    case (estado)
      OCIOSO: begin
        if (bus.iniciar) begin
          aceitar     = 1'b1;
          prox_estado = div0 ? FIM : CALCULA;
        end
      end
      CALCULA: begin
        if (cnt == CNT_W'(ITERACOES)) begin
          concluir    = 1'b1;
          prox_estado = FIM;
        end else begin
          passo = 1'b1;
        end
      end
      FIM:     prox_estado = OCIOSO;
      default: prox_estado = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dividendo_sh <= '0;
      divisor_r    <= '0;
      resto_parc   <= '0;
      quoc_r       <= '0;
`ifdef DIV_RESTO_EN
      resto_r      <= '0;
`endif
      cnt          <= '0;
      ocupado_r    <= 1'b0;
      pronto_r     <= 1'b0;
      erro_r       <= 1'b0;
    end else begin
      pronto_r <= (aceitar && div0) || concluir;
      if (aceitar) begin
        dividendo_sh <= bus.A;
        divisor_r    <= bus.B;
        resto_parc   <= '0;
        cnt          <= '0;
        ocupado_r    <= ~div0;
        if (div0) begin
          quoc_r <= QUOC_DIV0;
`ifdef DIV_RESTO_EN
          resto_r <= bus.A;
`endif
          erro_r <= 1'b1;
        end
      end
      // Dividend bits leave at the MSB while quotient bits enter at the LSB.
      if (passo) begin
        dividendo_sh <= {dividendo_sh[LARGURA-2:0], ~emprestimo};
        resto_parc   <= emprestimo ? parcial[LARGURA-1:0] : diferenca[LARGURA-1:0];
        cnt          <= cnt + 1'b1;
      end
      if (concluir) begin
        quoc_r    <= dividendo_sh;
`ifdef DIV_RESTO_EN
        resto_r   <= resto_parc;
`endif
        erro_r    <= 1'b0;
        ocupado_r <= 1'b0;
      end
    end
  end

  assign bus.quociente = quoc_r;
`ifdef DIV_RESTO_EN
  assign bus.resto     = resto_r;
`endif
  assign bus.ocupado   = ocupado_r;
  assign bus.pronto    = pronto_r;
  assign bus.erro_div0 = erro_r;

endmodule

// File: tb/tb_divisor_sequencial.sv
// Bench for divisor_sequencial: table of operations with a result scoreboard plus
// hand-written sequences for ignored restart and mid-operation reset.
module tb_divisor_sequencial;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       e;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    res_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total  = 0;
  int bad    = 0;
  int pulsos = 0;

  res_t sb[$];
  vec_t tab[9];

  divisor_sequencial_if bus ();

  divisor_sequencial dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: obtido=%0d esperado=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.pronto) begin
      pulsos++;
      if (sb.size() == 0) begin
        chk("pronto_inesperado", 1, 0);
      end else begin
        res_t x;
        x = sb.pop_front();
        chk("quociente", int'(bus.quociente), int'(x.q));
`ifdef DIV_RESTO_EN
        chk("resto", int'(bus.resto), int'(x.r));
`endif
        chk("erro_div0", int'(bus.erro_div0), int'(x.e));
      end
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_quociente"}, int'(bus.quociente), 0);
`ifdef DIV_RESTO_EN
    chk({nm, "_resto"}, int'(bus.resto), 0);
`endif
    chk({nm, "_ocupado"}, int'(bus.ocupado), 0);
    chk({nm, "_pronto"}, int'(bus.pronto), 0);
    chk({nm, "_erro_div0"}, int'(bus.erro_div0), 0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input res_t exp);
    int lat;
    int oc;
    sb.push_back(exp);
    @(negedge clk);
    bus.iniciar = 1'b1;
    bus.A       = a;
    bus.B       = b;
    @(negedge clk);
    bus.iniciar = 1'b0;
    bus.A       = 8'($urandom);
    bus.B       = 8'($urandom);
    lat = 0;
    oc  = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.pronto) begin
        lat = k;
        break;
      end
      if (bus.ocupado) oc++;
    end
    chk("latencia", lat, (b == 8'd0) ? 1 : 10);
    chk("ciclos_ocupado", oc, (b == 8'd0) ? 0 : 9);
    chk("ocupado_em_fim", int'(bus.ocupado), 0);
    @(negedge clk);
    chk("pronto_um_ciclo", int'(bus.pronto), 0);
    chk("quociente_mantido", int'(bus.quociente), int'(exp.q));
  endtask

  initial begin
    int p0;
    tab[0] = '{a: 8'd200, b: 8'd7,   exp: '{q: 8'd28,  r: 8'd4,   e: 1'b0}};
    tab[1] = '{a: 8'd5,   b: 8'd0,   exp: '{q: 8'hFF,  r: 8'd5,   e: 1'b1}};
    tab[2] = '{a: 8'd255, b: 8'd1,   exp: '{q: 8'd255, r: 8'd0,   e: 1'b0}};
    tab[3] = '{a: 8'd7,   b: 8'd200, exp: '{q: 8'd0,   r: 8'd7,   e: 1'b0}};
    tab[4] = '{a: 8'd0,   b: 8'd3,   exp: '{q: 8'd0,   r: 8'd0,   e: 1'b0}};
    tab[5] = '{a: 8'd255, b: 8'd255, exp: '{q: 8'd1,   r: 8'd0,   e: 1'b0}};
    tab[6] = '{a: 8'd1,   b: 8'd2,   exp: '{q: 8'd0,   r: 8'd1,   e: 1'b0}};
    tab[7] = '{a: 8'd0,   b: 8'd0,   exp: '{q: 8'hFF,  r: 8'd0,   e: 1'b1}};
    tab[8] = '{a: 8'd254, b: 8'd9,   exp: '{q: 8'd28,  r: 8'd2,   e: 1'b0}};

    bus.iniciar = 1'b1;
    bus.A       = 8'd17;
    bus.B       = 8'd3;
    rst         = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    bus.iniciar = 1'b0;
    rst         = 1'b0;

    for (int i = 0; i < 9; i++) run_op(tab[i].a, tab[i].b, tab[i].exp);

    // Restart request during iteration 4 must be ignored.
    sb.push_back('{q: 8'd10, r: 8'd0, e: 1'b0});
    p0 = pulsos;
    @(negedge clk);
    bus.iniciar = 1'b1;
    bus.A       = 8'd100;
    bus.B       = 8'd10;
    @(negedge clk);
    bus.iniciar = 1'b0;
    repeat (3) @(negedge clk);
    bus.iniciar = 1'b1;
    bus.A       = 8'd9;
    bus.B       = 8'd3;
    @(negedge clk);
    bus.iniciar = 1'b0;
    repeat (15) @(negedge clk);
    chk("pulso_unico", pulsos - p0, 1);

    // Reset in iteration 5 aborts silently, after a div-by-zero left nonzero outputs.
    run_op(8'd5, 8'd0, '{q: 8'hFF, r: 8'd5, e: 1'b1});
    p0 = pulsos;
    @(negedge clk);
    bus.iniciar = 1'b1;
    bus.A       = 8'd200;
    bus.B       = 8'd7;
    @(negedge clk);
    bus.iniciar = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("aborto");
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("sem_pronto_aborto", pulsos - p0, 0);
    run_op(8'd50, 8'd6, '{q: 8'd8, r: 8'd2, e: 1'b0});

    chk("scoreboard_vazio", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: obtido=running esperado=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/divisor_sequencial.md
DIVISOR_SEQUENCIAL -- requirements
Module: divisor_sequencial

Interface
REQ-001 Parameter: LARGURA, default 8, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 iniciar  input  1  start request, sampled every rising edge.
REQ-005 A  input  8  unsigned dividend.
REQ-006 B  input  8  unsigned divisor.
REQ-007 quociente  output  8  unsigned quotient, registered.
REQ-008 resto  output  8  unsigned remainder, registered; present only per REQ-027.
REQ-009 ocupado  output  1  high while a division is in progress.
REQ-010 pronto  output  1  one-cycle pulse marking valid results.
REQ-011 erro_div0  output  1  high when the last accepted operation had B = 0.

Function
REQ-012 The block SHALL implement a three-state FSM: OCIOSO, CALCULA and FIM.
REQ-013 In OCIOSO, iniciar=1 at an edge SHALL latch A and B, clear the iteration counter and the partial remainder, and set ocupado=1.
REQ-014 On acceptance with B != 0, the next state SHALL be CALCULA; with B = 0 it SHALL be FIM.
REQ-015 Each edge in CALCULA SHALL perform one restoring shift-subtract step, MSB first:
- shift the partial remainder left, bringing in the next dividend bit;
- if the 9-bit difference (remainder minus divisor) shows no borrow, keep the difference and set the quotient bit to 1;
- otherwise keep the remainder and set the quotient bit to 0.
REQ-016 After exactly 8 CALCULA iterations, the FSM SHALL enter FIM, updating quociente and resto on that same edge.
REQ-017 In FIM, pronto SHALL be 1 for exactly one cycle; the next state SHALL be OCIOSO, with ocupado=0 from that edge.
REQ-018 With B != 0, pronto SHALL be high in the 10th cycle after the accepting edge (latency 9 edges); with B = 0, it SHALL be high in the cycle directly after the accepting edge.
REQ-019 With B = 0, the block SHALL drive quociente=8'hFF, resto=A and erro_div0=1.
REQ-020 With B != 0, erro_div0 SHALL be 0 from the edge entering FIM.
REQ-021 iniciar SHALL be ignored in CALCULA and FIM; changes on A or B after acceptance SHALL have no effect.
REQ-022 quociente, resto and erro_div0 SHALL hold their values until the next completion or reset.
REQ-023 When A < B, the results SHALL be quociente=0 and resto=A; when A = 0, both SHALL be 0.

Reset
REQ-024 When rst=1 at an edge, the block SHALL:
- force OCIOSO;
- clear quociente, resto, ocupado, pronto, erro_div0, the counter and the internal registers to 0.
REQ-025 rst SHALL take priority over iniciar at the same edge.
REQ-026 Reset mid-operation SHALL abort it: no pronto pulse, and no partial result shall become visible.

Configuration
REQ-027 With macro DIV_RESTO_EN defined, the resto port and its register SHALL exist.
REQ-028 Without DIV_RESTO_EN, the resto port SHALL be absent, while quociente, timing and erro_div0 SHALL be unchanged.

Structure
REQ-029 A shared package SHALL hold:
- the LARGURA default;
- the iteration count (8);
- the FSM state encoding (OCIOSO=2'd0, CALCULA=2'd1, FIM=2'd2);
- the 8'hFF division-by-zero quotient constant.
REQ-030 One sub-module, subtrator9, SHALL compute the 9-bit difference and the borrow out, combinationally.

Verification
REQ-031 A=200, B=7, iniciar pulsed -> ocupado=1 for 9 cycles; pronto one cycle later with quociente=28, resto=4, erro_div0=0.
REQ-032 A=5, B=0 -> one cycle after acceptance: pronto=1, quociente=8'hFF, resto=5, erro_div0=1.
REQ-033 Boundary results:
- A=255, B=1 -> quociente=255, resto=0;
- A=7, B=200 -> quociente=0, resto=7;
- A=0, B=3 -> quociente=0, resto=0.
REQ-034 Start 100/10, then assert iniciar with A=9, B=3 in iteration 4 -> second request ignored; result 10, 0; a single pronto pulse.
REQ-035 Start 200/7, assert rst in iteration 5 -> all outputs 0 the following cycle; no pronto pulse; a new 50/6 then yields 8, 2.
REQ-036 Build without DIV_RESTO_EN, repeat REQ-031 -> quociente=28 with identical timing; no resto port present.
